// File: rtl/alu_share_arb.sv
// Two-requester arbiter/sequencer sharing one add/sub/mul datapath; results return on one tagged response channel.
// Define ALU_SHARE_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_share_arb #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [1:0]       i_req0_op,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [1:0]       i_req1_op,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_id,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_rsp_flag,
  output logic             o_busy
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  state_t             state;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               id_q;

  logic               grant1;
  logic               accept;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   calc_data;
  logic               calc_flag;

`ifdef ALU_SHARE_ARB_RR_EN
  logic last;

  // On a tie the requester not granted last wins; last resets to 1 so requester 0 wins first.
  assign grant1 = i_req1_valid & (~i_req0_valid | ~last);
`else
  assign grant1 = i_req1_valid & ~i_req0_valid;
`endif

  // Ready is gated by reset so it drops asynchronously together with the registered outputs.
  assign accept       = (state == IDLE) & (i_req0_valid | i_req1_valid) & i_rst_n;
  assign o_req0_ready = accept & ~grant1;
  assign o_req1_ready = accept & grant1;

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};
  assign prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    calc_data = '0;
    calc_flag = 1'b1;
    case (op_q)
      OP_ADD: begin
        calc_data = sum[WIDTH-1:0];
        calc_flag = sum[WIDTH];
      end
      OP_SUB: begin
        calc_data = diff[WIDTH-1:0];
        calc_flag = diff[WIDTH];
      end
      OP_MUL: begin
        calc_data = prod[WIDTH-1:0];
        calc_flag = |prod[2*WIDTH-1:WIDTH];
      end
      default: begin
        calc_data = '0;
        calc_flag = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_busy      <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_flag  <= 1'b0;
`ifdef ALU_SHARE_ARB_RR_EN
      last        <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= grant1 ? i_req1_op : i_req0_op;
            a_q    <= grant1 ? i_req1_a  : i_req0_a;
            b_q    <= grant1 ? i_req1_b  : i_req0_b;
            id_q   <= grant1;
            state  <= CALC;
            o_busy <= 1'b1;
`ifdef ALU_SHARE_ARB_RR_EN
            last   <= grant1;
`endif
          end
        end
        CALC: begin
          o_rsp_data  <= calc_data;
          o_rsp_flag  <= calc_flag;
          o_rsp_id    <= id_q;
          o_rsp_valid <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_busy      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          o_rsp_valid <= 1'b0;
          o_busy      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb: reset, each op, arbitration, backpressure, reset mid-operation.
module tb_alu_share_arb;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_flag, busy;
  logic [7:0] rsp_data;

  int total = 0;
  int bad   = 0;

  alu_share_arb #(.WIDTH(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req0_valid (req0_valid),
    .o_req0_ready (req0_ready),
    .i_req0_op    (req0_op),
    .i_req0_a     (req0_a),
    .i_req0_b     (req0_b),
    .i_req1_valid (req1_valid),
    .o_req1_ready (req1_ready),
    .i_req1_op    (req1_op),
    .i_req1_a     (req1_a),
    .i_req1_b     (req1_b),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_id     (rsp_id),
    .o_rsp_data   (rsp_data),
    .o_rsp_flag   (rsp_flag),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request alone, waits for grant and response; returns what the response carried.
  task automatic run_op(input logic rid, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] d, output logic f, output logic id_o, output int lat);
    int n;
    d = '0; f = 1'b0; id_o = 1'b0; lat = -1;
    @(negedge clk);
    rsp_ready = 1'b1;
    if (rid) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    #1;
    n = 0;
    while (!(rid ? req1_ready : req0_ready) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    if (!(rid ? req1_ready : req0_ready)) begin
      total++; bad++;
      $display("FAIL grant_timeout: requester %0d never granted", rid);
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!rsp_valid && n < 10);
    if (!rsp_valid) begin
      total++; bad++;
      $display("FAIL rsp_timeout: no response for requester %0d", rid);
      return;
    end
    d = rsp_data; f = rsp_flag; id_o = rsp_id; lat = n;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'd1; req0_b = 8'd1;
    req1_valid = 1'b0; req1_op = 2'b00; req1_a = 8'd0; req1_b = 8'd0;
    #1;
    total++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_flag, busy} !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs: got r0=%b r1=%b v=%b id=%b d=%0d f=%b busy=%b, want all 0",
               req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_flag, busy);
    end
    repeat (2) @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [7:0] d; logic f, id; int lat;
    run_op(1'b0, 2'b00, 8'd200, 8'd100, d, f, id, lat);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL add_latency: got %0d negedges, want 2", lat); end
    total++;
    if ({id, d, f} !== {1'b0, 8'd44, 1'b1}) begin
      bad++; $display("FAIL add_result: got id=%b d=%0d f=%b, want id=0 d=44 f=1", id, d, f);
    end
  endtask

  task automatic test_sub_mul();
    logic [7:0] d; logic f, id; int lat;
    run_op(1'b1, 2'b01, 8'd5, 8'd9, d, f, id, lat);
    total++;
    if ({id, d, f} !== {1'b1, 8'd252, 1'b1}) begin
      bad++; $display("FAIL sub_result: got id=%b d=%0d f=%b, want id=1 d=252 f=1", id, d, f);
    end
    run_op(1'b1, 2'b10, 8'd16, 8'd15, d, f, id, lat);
    total++;
    if ({id, d, f} !== {1'b1, 8'd240, 1'b0}) begin
      bad++; $display("FAIL mul_small: got id=%b d=%0d f=%b, want id=1 d=240 f=0", id, d, f);
    end
    run_op(1'b1, 2'b10, 8'd16, 8'd16, d, f, id, lat);
    total++;
    if ({id, d, f} !== {1'b1, 8'd0, 1'b1}) begin
      bad++; $display("FAIL mul_overflow: got id=%b d=%0d f=%b, want id=1 d=0 f=1", id, d, f);
    end
  endtask

  task automatic test_tie();
    logic       ids [4];
    logic [7:0] ds  [4];
    logic       exp_id [4];
    int got, n;
`ifdef ALU_SHARE_ARB_RR_EN
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_id = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    @(negedge clk);
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'd1; req0_b = 8'd2;
    req1_valid = 1'b1; req1_op = 2'b01; req1_a = 8'd9; req1_b = 8'd4;
    got = 0; n = 0;
    while (got < 4 && n < 40) begin
      @(negedge clk); n++;
      if (rsp_valid) begin
        ids[got] = rsp_id; ds[got] = rsp_data; got++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    total++;
    if (got !== 4) begin
      bad++; $display("FAIL tie_count: got %0d responses, want 4", got);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (ids[i] !== exp_id[i] || ds[i] !== (exp_id[i] ? 8'd5 : 8'd3)) begin
          bad++;
          $display("FAIL tie_grant%0d: got id=%b d=%0d, want id=%b d=%0d",
                   i, ids[i], ds[i], exp_id[i], exp_id[i] ? 5 : 3);
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'd10; req0_b = 8'd20;
    #1;
    total++;
    if (req0_ready !== 1'b1) begin bad++; $display("FAIL bp_grant: got ready0=%b, want 1", req0_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 2'b01; req1_a = 8'd50; req1_b = 8'd8;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_flag, req0_ready, req1_ready, busy} !== {1'b1, 1'b0, 8'd30, 1'b0, 1'b0, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL bp_hold%0d: got v=%b id=%b d=%0d f=%b r0=%b r1=%b busy=%b, want v=1 id=0 d=30 f=0 r0=0 r1=0 busy=1",
                 i, rsp_valid, rsp_id, rsp_data, rsp_flag, req0_ready, req1_ready, busy);
      end
      if (i < 4) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    total++;
    if ({rsp_valid, busy, req1_ready} !== 3'b001) begin
      bad++; $display("FAIL bp_release: got v=%b busy=%b r1=%b, want v=0 busy=0 r1=1", rsp_valid, busy, req1_ready);
    end
    req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reserved();
    logic [7:0] d; logic f, id; int lat;
    run_op(1'b1, 2'b11, 8'd7, 8'd3, d, f, id, lat);
    total++;
    if ({id, d, f} !== {1'b1, 8'd0, 1'b1}) begin
      bad++; $display("FAIL reserved: got id=%b d=%0d f=%b, want id=1 d=0 f=1", id, d, f);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'd200; req0_b = 8'd100;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 2'b00; req1_a = 8'd3; req1_b = 8'd4;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_flag, busy} !== 15'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got r0=%b r1=%b v=%b id=%b d=%0d f=%b busy=%b, want all 0",
               req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_flag, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      bad++; $display("FAIL mid_regrant: got r0=%b r1=%b, want r0=0 r1=1", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
    total++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_flag} !== {1'b1, 1'b1, 8'd7, 1'b0}) begin
      bad++;
      $display("FAIL mid_first_rsp: got v=%b id=%b d=%0d f=%b, want v=1 id=1 d=7 f=0",
               rsp_valid, rsp_id, rsp_data, rsp_flag);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_mul();
    test_tie();
    test_backpressure();
    test_reserved();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
